// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with a valid/ready input
// and a held display result. Optional build macro BCD_SATURATE_EN selects "9999" instead of "EEEE" on overflow.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin,
    output logic [4*DIGITS-1:0] data,
    output logic                disp_en,
    output logic                ovf,
    output logic                done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

`ifdef BCD_SATURATE_EN
    localparam logic [BCD_W-1:0] OVF_FILL = {DIGITS{4'h9}};
`else
    localparam logic [BCD_W-1:0] OVF_FILL = {DIGITS{4'hE}};
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic [BCD_W-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             disp_en_q, disp_en_d;
    logic             done_q, done_d;

    logic [SR_W-1:0]  sr_adj;
    logic [31:0]      bin_ext;

    assign bin_ext = 32'(bin);

    // Digits sit above the binary bits; each one >= 5 is corrected before the shift.
    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = sr_q[BIN_W + 4*gi +: 4];
            assign sr_adj[BIN_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
        disp_en_d = disp_en_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_SHIFT;
                    sr_d      = {{BCD_W{1'b0}}, bin};
                    cnt_d     = '0;
                    ovf_int_d = (bin_ext > MAX_VAL);
                end
            end
            S_SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                data_d    = ovf_int_q ? OVF_FILL : sr_q[SR_W-1 -: BCD_W];
                ovf_d     = ovf_int_q;
                disp_en_d = 1'b1;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            disp_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            disp_en_q <= disp_en_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign data     = data_q;
    assign ovf      = ovf_q;
    assign disp_en  = disp_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4): latency, back-to-back,
// overflow fill, busy-input rejection and mid-conversion reset.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] bin;
    logic [15:0] data;
    logic        disp_en;
    logic        ovf;
    logic        done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

`ifdef BCD_SATURATE_EN
    localparam logic [15:0] OVF_EXP = 16'h9999;
`else
    localparam logic [15:0] OVF_EXP = 16'hEEEE;
`endif

    localparam int NVEC = 8;
    localparam logic [13:0] VIN  [NVEC] = '{14'd1, 14'd9, 14'd10, 14'd99,
                                             14'd100, 14'd5050, 14'd8765, 14'd7};
    localparam logic [15:0] VEXP [NVEC] = '{16'h0001, 16'h0009, 16'h0010, 16'h0099,
                                             16'h0100, 16'h5050, 16'h8765, 16'h0007};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin      (bin),
        .data     (data),
        .disp_en  (disp_en),
        .ovf      (ovf),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the converter should be idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [13:0] v);
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        bin      = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until done is observed; optionally drives noise while busy.
    task automatic wait_done(input bit noisy, output int lat, output int done_cyc);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (noisy && done !== 1'b1) begin
                in_valid = 1'($urandom_range(0, 1));
                bin      = 14'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        done_cyc = cyc;
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic convert(input logic [13:0] v, input logic [15:0] exp_data,
                           input logic exp_ovf, input bit noisy);
        int lat;
        int dc;
        issue(v);
        wait_done(noisy, lat, dc);
        $display("conv bin=%0d data=%h ovf=%b lat=%0d", v, data, ovf, lat);
        check("latency", lat, 32'd15);
        check("data", {16'd0, data}, {16'd0, exp_data});
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        check("disp_en", {31'd0, disp_en}, 32'd1);
        check("ready_in_done", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int dc0;
        int dc1;
        int extra;

        rst = 1'b1;
        in_valid = 1'b0;
        bin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_data", {16'd0, data}, 32'd0);
        check("rst_disp_en", {31'd0, disp_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);

        convert(14'd1234, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Back-to-back: second value accepted on the first result's done cycle.
        issue(14'd0);
        wait_done(1'b0, lat, dc0);
        $display("conv bin=0 data=%h ovf=%b lat=%0d", data, ovf, lat);
        check("b2b0_data", {16'd0, data}, 32'h0000);
        check("b2b0_lat", lat, 32'd15);
        issue(14'd9999);
        wait_done(1'b0, lat, dc1);
        $display("conv bin=9999 data=%h ovf=%b lat=%0d", data, ovf, lat);
        check("b2b1_data", {16'd0, data}, 32'h9999);
        check("b2b_spacing", dc1 - dc0, 32'd16);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            convert(VIN[i], VEXP[i], 1'b0, 1'b0);
        end

        @(negedge clk);
        convert(14'd10000, OVF_EXP, 1'b1, 1'b0);
        @(negedge clk);
        convert(14'd16383, OVF_EXP, 1'b1, 1'b0);
        @(negedge clk);
        convert(14'd9998, 16'h9998, 1'b0, 1'b0);

        // Results hold while idle.
        repeat (5) @(negedge clk);
        check("hold_data", {16'd0, data}, 32'h9998);
        check("hold_disp_en", {31'd0, disp_en}, 32'd1);

        // Noise on in_valid/bin while busy must not disturb or queue anything.
        convert(14'd4321, 16'h4321, 1'b0, 1'b1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("single_done", extra, 32'd0);
        check("noise_data_held", {16'd0, data}, 32'h4321);

        // Reset asserted at the 7th shift edge aborts the conversion.
        issue(14'd5678);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        $display("abort bin=5678 data=%h disp_en=%b dones=%0d", data, disp_en, extra);
        check("abort_no_done", extra, 32'd0);
        check("abort_data", {16'd0, data}, 32'h0000);
        check("abort_disp_en", {31'd0, disp_en}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        convert(14'd42, 16'h0042, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
